mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/counter_pkg.sv | 12 +
 rtl/mod_counter_next.sv | 28 ++
 rtl/mod_counter.sv | 78 +++++++
 tb/tb_mod_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared counter definitions: direction encodings and parameter legality check.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // MODULUS must lie in 2..2**WIDTH.
  function automatic bit modulus_legal(input int unsigned width, input int unsigned modulus);
    return (modulus >= 32'd2) && (64'(modulus) <= (64'd1 << width));
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Next-count computation for the modulo counter: up/down with wrap or saturate at the ends.
module mod_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULUS  = 6,
  parameter int unsigned SATURATE = 0
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up_down,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  localparam bit               SAT = (SATURATE != 0);

  always_comb begin
    nxt = cur;
    if (up_down == DIR_UP) begin
      if (cur == TOP) nxt = SAT ? cur : '0;
      else            nxt = cur + WIDTH'(1);
    end else begin
      if (cur == '0)  nxt = SAT ? cur : TOP;
      else            nxt = cur - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with clear/load priority, wrap pulse, illegal-load pulse and wrap tally.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned MODULUS    = 6,
  parameter int unsigned SATURATE   = 0,
  parameter int unsigned WRAP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err,
  output logic [WRAP_WIDTH-1:0] wrap_count
);

  localparam logic [WIDTH-1:0]      TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]        MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WRAP_WIDTH-1:0] WC_MAX  = '1;

  if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_counter: MODULUS out of range 2..2**WIDTH");
  end

  logic [WIDTH-1:0] nxt;
  logic             load_bad;

  mod_counter_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .cur     (out),
    .up_down (up_down),
    .nxt     (nxt)
  );

  assign load_bad = ({1'b0, load_value} >= MOD_EXT);

  // Terminal count only when an enabled advance would hit the sequence end.
  always_comb begin
    tc = 1'b0;
    if (enable && !clear && !load)
      tc = (up_down == DIR_UP) ? (out == TOP) : (out == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= '0;
      wrap       <= 1'b0;
      load_err   <= 1'b0;
      wrap_count <= '0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        out        <= '0;
        wrap_count <= '0;
      end else if (load) begin
        out      <= load_bad ? TOP : load_value;
        load_err <= load_bad;
      end else if (enable) begin
        out  <= nxt;
        wrap <= tc;
        if (tc && (wrap_count != WC_MAX))
          wrap_count <= wrap_count + WRAP_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Randomised self-checking bench for mod_counter: three parameterisations share one stimulus stream.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, up_down, clear, load;
  logic [2:0] load_value;

  logic [2:0] o_out [3];
  logic       o_tc [3];
  logic       o_wrap [3];
  logic       o_err [3];
  logic [7:0] wc0, wc1;
  logic [1:0] wc2;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state per instance: 0 = defaults, 1 = saturating, 2 = 2-bit wrap tally.
  int m_out [3], m_wrap [3], m_err [3], m_wc [3];
  int p_sat [3]  = '{0, 1, 0};
  int p_wcmx [3] = '{255, 255, 3};
  localparam int M = 6;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0), .WRAP_WIDTH(8)) u_def (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
    .load_value(load_value), .out(o_out[0]), .tc(o_tc[0]), .wrap(o_wrap[0]), .load_err(o_err[0]),
    .wrap_count(wc0));

  mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1), .WRAP_WIDTH(8)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
    .load_value(load_value), .out(o_out[1]), .tc(o_tc[1]), .wrap(o_wrap[1]), .load_err(o_err[1]),
    .wrap_count(wc1));

  mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0), .WRAP_WIDTH(2)) u_ww (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
    .load_value(load_value), .out(o_out[2]), .tc(o_tc[2]), .wrap(o_wrap[2]), .load_err(o_err[2]),
    .wrap_count(wc2));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_wc(input int i);
    case (i)
      0:       return int'(wc0);
      1:       return int'(wc1);
      default: return int'(wc2);
    endcase
  endfunction

  function automatic int model_tc(input int i);
    if (!enable || clear || load) return 0;
    return up_down ? int'(m_out[i] == M - 1) : int'(m_out[i] == 0);
  endfunction

  // Reference behaviour from the counter rules, in plain integer arithmetic.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_out[i] = 0; m_wrap[i] = 0; m_err[i] = 0; m_wc[i] = 0;
      end else begin
        int t;
        t = model_tc(i);
        m_wrap[i] = 0;
        m_err[i]  = 0;
        if (clear) begin
          m_out[i] = 0; m_wc[i] = 0;
        end else if (load) begin
          m_err[i] = int'(int'(load_value) >= M);
          m_out[i] = m_err[i] != 0 ? M - 1 : int'(load_value);
        end else if (enable) begin
          m_wrap[i] = t;
          if (up_down) m_out[i] = p_sat[i] != 0 ? ((m_out[i] + 1 > M - 1) ? M - 1 : m_out[i] + 1)
                                                : (m_out[i] + 1) % M;
          else         m_out[i] = p_sat[i] != 0 ? ((m_out[i] - 1 < 0) ? 0 : m_out[i] - 1)
                                                : (m_out[i] + M - 1) % M;
          if (t != 0 && m_wc[i] < p_wcmx[i]) m_wc[i] = m_wc[i] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("out[%0d]", i),      int'(o_out[i]),  m_out[i]);
        check($sformatf("tc[%0d]", i),       int'(o_tc[i]),   model_tc(i));
        check($sformatf("wrap[%0d]", i),     int'(o_wrap[i]), m_wrap[i]);
        check($sformatf("load_err[%0d]", i), int'(o_err[i]),  m_err[i]);
        check($sformatf("wrap_count[%0d]", i), dut_wc(i),     m_wc[i]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic ud, input logic clr, input logic ld, input logic [2:0] lv);
    enable = en; up_down = ud; clear = clr; load = ld; load_value = lv;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    #10 reset = 1'b0;
    #1 chk_en = 1'b1;

    // Up count from reset: two wraps in 12 cycles; saturating copy pins at 5.
    step(12);
    check("up12.def.out", int'(o_out[0]), 0);
    check("up12.def.wrap", int'(o_wrap[0]), 1);
    check("up12.def.wc", int'(wc0), 2);
    check("up12.sat.out", int'(o_out[1]), 5);
    check("up12.sat.tc", int'(o_tc[1]), 1);
    check("up12.sat.wc", int'(wc1), 7);
    step(18);
    check("up30.def.wc", int'(wc0), 5);
    check("up30.ww.wc_sat", int'(wc2), 3);

    // Clear, then count down through the 0 -> 5 wrap.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    step(1);
    check("clr.def.out", int'(o_out[0]), 0);
    check("clr.def.wc", int'(wc0), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1);
    check("dn1.def.out", int'(o_out[0]), 5);
    check("dn1.def.wrap", int'(o_wrap[0]), 1);
    check("dn1.sat.out", int'(o_out[1]), 0);
    step(6);
    check("dn7.def.out", int'(o_out[0]), 5);
    check("dn7.def.wc", int'(wc0), 2);

    // Illegal load clamps to MODULUS-1; load beats enable.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd7);
    step(1);
    check("ld7.def.out", int'(o_out[0]), 5);
    check("ld7.def.err", int'(o_err[0]), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd3);
    step(1);
    check("ld3.def.out", int'(o_out[0]), 3);
    check("ld3.def.err", int'(o_err[0]), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1);
    check("inc.def.out", int'(o_out[0]), 4);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
    step(1);
    check("clrall.def.out", int'(o_out[0]), 0);
    check("clrall.def.wrap", int'(o_wrap[0]), 0);

    // Asynchronous reset mid-cycle right after a wrap.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    step(6);
    check("pre_rst.def.wrap", int'(o_wrap[0]), 1);
    check("pre_rst.def.wc", int'(wc0), 1);
    #2 reset = 1'b1;
    #1;
    check("arst.def.wrap", int'(o_wrap[0]), 0);
    check("arst.def.wc", int'(wc0), 0);
    check("arst.sat.out", int'(o_out[1]), 0);
    check("arst.ww.wc", int'(wc2), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomised traffic with occasional reset.
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 99) < 75, 1'($urandom), $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 10, 3'($urandom));
      reset = ($urandom_range(0, 199) == 0);
      step(1);
      reset = 1'b0;
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
